alarm_ctrl: RTL

//  Alarm controller downstream of the hour/minute/second time registers built from bit cells.

---
 rtl/alarm_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/alarm_ctrl.sv
// alarm_ctrl -- alarm controller for the bit-cell time registers.
//
// Compares the live hour/minute/second against the alarm hour/minute and
// runs the IDLE / ARMED / RINGING / SNOOZE state machine that drives the
// buzzer. All timing is paced by tick_1hz, the same pulse that increments
// the seconds register.
//
// Parameters:
//   SNOOZE_SECS        snooze length in tick_1hz periods (>=1)
//   RING_TIMEOUT_SECS  ring duration in ticks before auto-stop (>=1)
//   SNOOZE_MAX         snoozes allowed per alarm event (0 disables snooze)
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   tick_1hz        one-cycle pulse per second
//   time_h/m/s      current time (hour 0-23, minute 0-59, second 0-59)
//   alarm_h/m       alarm time (hour, minute)
//   arm_en          level, alarm enabled; low forces IDLE
//   snooze_btn      synchronised snooze button
//   stop_btn        synchronised stop button
//   buzzer          buzzer drive
//   ringing         state is RINGING
//   snoozing        state is SNOOZE
//   snooze_left     snoozes remaining in the current event (saturates at 3)
//   state_dbg       raw FSM state for debug/checkers
//
// Build option:
//   BEEP_PATTERN_EN  when defined, the buzzer beeps 1 s on / 1 s off while
//                    ringing (starting on); otherwise it is steady.

module alarm_ctrl #(
    parameter int SNOOZE_SECS       = 540,
    parameter int RING_TIMEOUT_SECS = 60,
    parameter int SNOOZE_MAX        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic [4:0] time_h,
    input  logic [5:0] time_m,
    input  logic [5:0] time_s,
    input  logic [4:0] alarm_h,
    input  logic [5:0] alarm_m,
    input  logic       arm_en,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [1:0] snooze_left,
    output logic [1:0] state_dbg
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] RINGING = 2'd2;
    localparam logic [1:0] SNOOZE  = 2'd3;

    localparam int RW = $clog2(RING_TIMEOUT_SECS + 1);
    localparam int SW = $clog2(SNOOZE_SECS + 1);

    localparam logic [RW-1:0] RING_LAST = RW'(RING_TIMEOUT_SECS - 1);
    localparam logic [SW-1:0] SNZ_LOAD  = SW'(SNOOZE_SECS);
    localparam logic [SW-1:0] SNZ_ONE   = SW'(1);
    // snooze_left is only 2 bits wide, so the per-event budget saturates at 3.
    localparam logic [1:0]    SNZ_INIT  = (SNOOZE_MAX > 3) ? 2'd3 : 2'(SNOOZE_MAX);

    logic [1:0]    state;
    logic [RW-1:0] ring_cnt;
    logic [SW-1:0] snz_cnt;
    logic          match;
    logic          match_q;
    logic          trig;

    // The seconds==0 term plus the edge detect makes the alarm fire exactly
    // once per alarm minute, even though match stays true for a whole second.
    assign match = (time_h == alarm_h) && (time_m == alarm_m) && (time_s == 6'd0);
    assign trig  = match && !match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ring_cnt    <= '0;
            snz_cnt     <= '0;
            snooze_left <= 2'd0;
            match_q     <= 1'b0;
        end else begin
            match_q <= match;
            if (!arm_en) begin
                state       <= IDLE;
                ring_cnt    <= '0;
                snz_cnt     <= '0;
                snooze_left <= 2'd0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (trig) begin
                            state       <= RINGING;
                            ring_cnt    <= '0;
                            snooze_left <= SNZ_INIT;
                        end
                    end
                    RINGING: begin
                        // Stop has priority over snooze; an unusable snooze
                        // press is treated as if it were not there.
                        if (stop_btn) begin
                            state <= ARMED;
                        end else if (snooze_btn && (snooze_left != 2'd0)) begin
                            state       <= SNOOZE;
                            snz_cnt     <= SNZ_LOAD;
                            snooze_left <= snooze_left - 2'd1;
                        end else if (tick_1hz) begin
                            if (ring_cnt == RING_LAST) begin
                                state <= ARMED;
                            end else begin
                                ring_cnt <= ring_cnt + 1'b1;
                            end
                        end
                    end
                    SNOOZE: begin
                        // snooze_btn is ignored here so a held button cannot
                        // chain snoozes.
                        if (stop_btn) begin
                            state <= ARMED;
                        end else if (tick_1hz) begin
                            if (snz_cnt == SNZ_ONE) begin
                                state    <= RINGING;
                                ring_cnt <= '0;
                            end else begin
                                snz_cnt <= snz_cnt - 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign ringing   = (state == RINGING);
    assign snoozing  = (state == SNOOZE);
    assign state_dbg = state;

`ifdef BEEP_PATTERN_EN
    logic beep_ph;

    // Held at 0 outside RINGING, so every entry into RINGING starts "on".
    always_ff @(posedge clk) begin
        if (rst || !arm_en || (state != RINGING)) begin
            beep_ph <= 1'b0;
        end else if (tick_1hz) begin
            beep_ph <= ~beep_ph;
        end
    end

    assign buzzer = ringing && !beep_ph;
`else
    assign buzzer = ringing;
`endif

endmodule
